// File: rtl/wb_led_pwm.sv
// Wishbone slave with per-channel PWM duty registers, a shared prescaler/phase
// counter, global enable/invert control and error response on unmapped offsets.
module wb_led_pwm #(
    parameter int unsigned              WB_BUS_WIDTH  = 16,
    parameter int unsigned              WB_ADDR_WIDTH = 32,
    parameter logic [WB_ADDR_WIDTH-1:0] WB_BUS_ADDR   = WB_ADDR_WIDTH'(32'h0000_00A0),
    parameter int unsigned              CHANNELS      = 8,
    parameter int unsigned              PWM_WIDTH     = 8
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_reset_i,
    input  logic [WB_BUS_WIDTH-1:0]   wb_data_i,
    input  logic [WB_ADDR_WIDTH-1:0]  wb_addr_i,
    input  logic                      wb_cyc_i,
    input  logic                      wb_lock_i,
    input  logic [WB_BUS_WIDTH/8-1:0] wb_sel_i,
    input  logic                      wb_stb_i,
    input  logic                      wb_we_i,
    output logic [WB_BUS_WIDTH-1:0]   wb_data_o,
    output logic                      wb_ack_o,
    output logic                      wb_stall_o,
    output logic                      wb_err_o,
    output logic                      wb_rty_o,
    output logic [CHANNELS-1:0]       leds_o
);

    localparam int unsigned WB_SEL   = WB_BUS_WIDTH / 8;
    localparam int unsigned ADDR_LSB = $clog2(WB_SEL);
    localparam int unsigned IDX_W    = $clog2(CHANNELS + 2);
    localparam int unsigned TAG_LSB  = ADDR_LSB + IDX_W;

    logic                    ctrl_en;
    logic                    ctrl_inv;
    logic [WB_BUS_WIDTH-1:0] prescale;
    logic [PWM_WIDTH-1:0]    duty [CHANNELS];
    logic [WB_BUS_WIDTH-1:0] pcnt;
    logic [PWM_WIDTH-1:0]    phase;

    logic                    hit_c;
    logic [IDX_W-1:0]        idx_c;
    logic                    access_c;
    logic                    mapped_c;
    logic                    wr_c;
    logic                    ctrl_wr_c;
    logic                    pre_wr_c;
    logic [WB_BUS_WIDTH-1:0] ctrl_merged_c;
    logic [WB_BUS_WIDTH-1:0] pre_merged_c;
    logic [WB_BUS_WIDTH-1:0] rd_data_c;
    logic                    unused_c;

    // Byte-lane write merge: unselected lanes keep the old register byte.
    function automatic logic [WB_BUS_WIDTH-1:0] merge_lanes(
        input logic [WB_BUS_WIDTH-1:0] old_v,
        input logic [WB_BUS_WIDTH-1:0] new_v,
        input logic [WB_SEL-1:0]       sel
    );
        logic [WB_BUS_WIDTH-1:0] r;
        r = old_v;
        for (int i = 0; i < WB_SEL; i++) begin
            if (sel[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
        end
        return r;
    endfunction

    assign hit_c     = (wb_addr_i[WB_ADDR_WIDTH-1:TAG_LSB] == WB_BUS_ADDR[WB_ADDR_WIDTH-1:TAG_LSB]);
    assign idx_c     = wb_addr_i[ADDR_LSB +: IDX_W];
    assign access_c  = wb_cyc_i & wb_stb_i & hit_c;
    assign mapped_c  = (32'(idx_c) < CHANNELS + 2);
    assign wr_c      = access_c & mapped_c & wb_we_i;
    assign ctrl_wr_c = wr_c & (idx_c == IDX_W'(0));
    assign pre_wr_c  = wr_c & (idx_c == IDX_W'(1));

    assign ctrl_merged_c = merge_lanes(WB_BUS_WIDTH'({ctrl_inv, ctrl_en}), wb_data_i, wb_sel_i);
    assign pre_merged_c  = merge_lanes(prescale, wb_data_i, wb_sel_i);

    assign wb_stall_o = 1'b0;
    assign wb_rty_o   = 1'b0;
    assign unused_c   = ^{wb_lock_i, wb_addr_i};

    // Read mux over the register map; unmapped indices read as zero.
    always_comb begin
        rd_data_c = '0;
        if (idx_c == IDX_W'(0)) rd_data_c = WB_BUS_WIDTH'({ctrl_inv, ctrl_en});
        if (idx_c == IDX_W'(1)) rd_data_c = prescale;
        for (int k = 0; k < CHANNELS; k++) begin
            if (idx_c == IDX_W'(k + 2)) rd_data_c = WB_BUS_WIDTH'(duty[k]);
        end
    end

    // Bus response: one ack or err per accepted access, read data held until next read.
    always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
        if (wb_reset_i) begin
            wb_ack_o  <= 1'b0;
            wb_err_o  <= 1'b0;
            wb_data_o <= '0;
        end else begin
            wb_ack_o <= access_c & mapped_c;
            wb_err_o <= access_c & ~mapped_c;
            if (access_c & ~mapped_c) begin
                wb_data_o <= '0;
            end else if (access_c & ~wb_we_i) begin
                wb_data_o <= rd_data_c;
            end
        end
    end

    // Register file writes.
    always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
        if (wb_reset_i) begin
            ctrl_en  <= 1'b0;
            ctrl_inv <= 1'b0;
            prescale <= '0;
            for (int k = 0; k < CHANNELS; k++) duty[k] <= '0;
        end else begin
            if (ctrl_wr_c) begin
                ctrl_en  <= ctrl_merged_c[0];
                ctrl_inv <= ctrl_merged_c[1];
            end
            if (pre_wr_c) prescale <= pre_merged_c;
            for (int k = 0; k < CHANNELS; k++) begin
                if (wr_c && idx_c == IDX_W'(k + 2)) begin
                    duty[k] <= PWM_WIDTH'(merge_lanes(WB_BUS_WIDTH'(duty[k]), wb_data_i, wb_sel_i));
                end
            end
        end
    end

    // Prescaler and phase counter; a CTRL or PRESCALE write restarts both.
    always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
        if (wb_reset_i) begin
            pcnt  <= '0;
            phase <= '0;
        end else if (ctrl_wr_c | pre_wr_c) begin
            pcnt  <= '0;
            phase <= '0;
        end else if (pcnt == prescale) begin
            pcnt  <= '0;
            phase <= phase + PWM_WIDTH'(1);
        end else begin
            pcnt  <= pcnt + WB_BUS_WIDTH'(1);
        end
    end

    // PWM compare per channel, then global enable and polarity.
    always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
        if (wb_reset_i) begin
            leds_o <= '0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                leds_o[k] <= (ctrl_en & (phase < duty[k])) ^ ctrl_inv;
            end
        end
    end

endmodule

// File: tb/tb_wb_led_pwm.sv
// Directed self-checking bench for wb_led_pwm with default parameters.
module tb_wb_led_pwm;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] wb_wdata;
    logic [31:0] wb_addr;
    logic        wb_cyc;
    logic        wb_lock;
    logic [1:0]  wb_sel;
    logic        wb_stb;
    logic        wb_we;
    logic [15:0] wb_rdata;
    logic        wb_ack;
    logic        wb_stall;
    logic        wb_err;
    logic        wb_rty;
    logic [7:0]  leds;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_led_pwm dut (
        .wb_clk_i   (clk),
        .wb_reset_i (rst),
        .wb_data_i  (wb_wdata),
        .wb_addr_i  (wb_addr),
        .wb_cyc_i   (wb_cyc),
        .wb_lock_i  (wb_lock),
        .wb_sel_i   (wb_sel),
        .wb_stb_i   (wb_stb),
        .wb_we_i    (wb_we),
        .wb_data_o  (wb_rdata),
        .wb_ack_o   (wb_ack),
        .wb_stall_o (wb_stall),
        .wb_err_o   (wb_err),
        .wb_rty_o   (wb_rty),
        .leds_o     (leds)
    );

    // Single-cycle bus access; returns response in the accept cycle and the one after.
    task automatic bus(input logic [31:0] addr, input logic [15:0] data, input logic [1:0] sel,
                       input logic we, output logic a1, output logic e1, output logic [15:0] rd,
                       output logic a2, output logic e2);
        @(negedge clk);
        wb_addr = addr; wb_wdata = data; wb_sel = sel; wb_we = we; wb_cyc = 1'b1; wb_stb = 1'b1;
        @(posedge clk); #1;
        a1 = wb_ack; e1 = wb_err; rd = wb_rdata;
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(posedge clk); #1;
        a2 = wb_ack; e2 = wb_err;
    endtask

    task automatic test_reset();
        logic a1, e1, a2, e2;
        logic [15:0] rd;
        checks++;
        if ({wb_ack, wb_err, leds, wb_rdata} !== 26'd0) begin
            errors++; $display("FAIL reset_outputs: got ack=%b err=%b leds=%h data=%h want all 0", wb_ack, wb_err, leds, wb_rdata);
        end
        checks++;
        if ({wb_stall, wb_rty} !== 2'b00) begin
            errors++; $display("FAIL tied_outputs: got stall=%b rty=%b want 0 0", wb_stall, wb_rty);
        end
        @(negedge clk) rst = 1'b0;
        bus(32'hA0, 16'h0002, 2'b01, 1'b1, a1, e1, rd, a2, e2);
        bus(32'hA4, 16'h0055, 2'b11, 1'b1, a1, e1, rd, a2, e2);
        checks++;
        if (leds !== 8'hFF) begin
            errors++; $display("FAIL inv_disabled: got leds=%h want ff", leds);
        end
        // Reset while an ack is showing: it must vanish without a clock edge.
        @(negedge clk);
        wb_addr = 32'hA0; wb_we = 1'b0; wb_sel = 2'b11; wb_cyc = 1'b1; wb_stb = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (wb_ack !== 1'b1 || wb_rdata !== 16'h0002) begin
            errors++; $display("FAIL pre_reset_read: got ack=%b data=%h want 1 0002", wb_ack, wb_rdata);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({wb_ack, wb_err, leds, wb_rdata} !== 26'd0) begin
            errors++; $display("FAIL async_reset_ack: got ack=%b err=%b leds=%h data=%h want all 0", wb_ack, wb_err, leds, wb_rdata);
        end
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (wb_ack !== 1'b0 || wb_err !== 1'b0) begin
            errors++; $display("FAIL reset_drops_resp: got ack=%b err=%b want 0 0", wb_ack, wb_err);
        end
        // Same for a pending err.
        @(negedge clk);
        wb_addr = 32'hB4; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (wb_err !== 1'b1) begin
            errors++; $display("FAIL pre_reset_err: got err=%b want 1", wb_err);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (wb_err !== 1'b0 || wb_ack !== 1'b0) begin
            errors++; $display("FAIL async_reset_err: got err=%b ack=%b want 0 0", wb_err, wb_ack);
        end
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0; rst = 1'b0;
        bus(32'hA0, 16'h0000, 2'b11, 1'b0, a1, e1, rd, a2, e2);
        checks++;
        if (a1 !== 1'b1 || rd !== 16'h0000) begin
            errors++; $display("FAIL reset_ctrl_read: got ack=%b data=%h want 1 0000", a1, rd);
        end
        bus(32'hA4, 16'h0000, 2'b11, 1'b0, a1, e1, rd, a2, e2);
        checks++;
        if (a1 !== 1'b1 || rd !== 16'h0000) begin
            errors++; $display("FAIL reset_duty_read: got ack=%b data=%h want 1 0000", a1, rd);
        end
    endtask

    task automatic test_byte_lanes();
        logic a1, e1, a2, e2;
        logic [15:0] rd;
        bus(32'hA2, 16'hABCD, 2'b01, 1'b1, a1, e1, rd, a2, e2);
        checks++;
        if ({a1, e1, a2, e2} !== 4'b1000) begin
            errors++; $display("FAIL lane_write_ack: got ack/err/ack+1/err+1=%b want 1000", {a1, e1, a2, e2});
        end
        bus(32'hA2, 16'h0000, 2'b11, 1'b0, a1, e1, rd, a2, e2);
        checks++;
        if (rd !== 16'h00CD || {a1, a2} !== 2'b10) begin
            errors++; $display("FAIL lane_low: got data=%h acks=%b want 00cd 10", rd, {a1, a2});
        end
        bus(32'hA2, 16'h1234, 2'b10, 1'b1, a1, e1, rd, a2, e2);
        bus(32'hA2, 16'h0000, 2'b11, 1'b0, a1, e1, rd, a2, e2);
        checks++;
        if (rd !== 16'h12CD || {a1, a2} !== 2'b10) begin
            errors++; $display("FAIL lane_high: got data=%h acks=%b want 12cd 10", rd, {a1, a2});
        end
    endtask

    task automatic test_error();
        logic a1, e1, a2, e2;
        logic [15:0] rd;
        bus(32'hB4, 16'h0000, 2'b11, 1'b0, a1, e1, rd, a2, e2);
        checks++;
        if ({a1, e1, a2, e2} !== 4'b0100 || rd !== 16'h0000) begin
            errors++; $display("FAIL unmapped_err: got ack/err/ack+1/err+1=%b data=%h want 0100 0000", {a1, e1, a2, e2}, rd);
        end
        bus(32'hC0, 16'h0000, 2'b11, 1'b0, a1, e1, rd, a2, e2);
        checks++;
        if ({a1, e1, a2, e2} !== 4'b0000) begin
            errors++; $display("FAIL miss_read: got ack/err/ack+1/err+1=%b want 0000", {a1, e1, a2, e2});
        end
        bus(32'hC2, 16'hFFFF, 2'b11, 1'b1, a1, e1, rd, a2, e2);
        checks++;
        if ({a1, e1} !== 2'b00) begin
            errors++; $display("FAIL miss_write: got ack=%b err=%b want 0 0", a1, e1);
        end
        bus(32'hA2, 16'h0000, 2'b11, 1'b0, a1, e1, rd, a2, e2);
        checks++;
        if (rd !== 16'h12CD) begin
            errors++; $display("FAIL miss_no_effect: got prescale=%h want 12cd", rd);
        end
    endtask

    task automatic test_pwm();
        logic a1, e1, a2, e2;
        logic [15:0] rd;
        logic p;
        int hi0, hi2, hi1, tr0;
        bus(32'hA2, 16'h0000, 2'b11, 1'b1, a1, e1, rd, a2, e2);
        bus(32'hA4, 16'h0040, 2'b11, 1'b1, a1, e1, rd, a2, e2);
        bus(32'hA8, 16'h00FF, 2'b11, 1'b1, a1, e1, rd, a2, e2);
        bus(32'hA0, 16'h0001, 2'b11, 1'b1, a1, e1, rd, a2, e2);
        for (int w = 0; w < 2; w++) begin
            hi0 = 0; hi1 = 0; hi2 = 0; tr0 = 0;
            p = leds[0];
            for (int c = 0; c < 256; c++) begin
                @(posedge clk); #1;
                if (leds[0]) hi0++;
                if (leds[1]) hi1++;
                if (leds[2]) hi2++;
                if (leds[0] !== p) tr0++;
                p = leds[0];
            end
            checks++;
            if (hi0 != 64 || tr0 != 2) begin
                errors++; $display("FAIL pwm_duty64: window %0d high=%0d edges=%0d want 64 2", w, hi0, tr0);
            end
            checks++;
            if (hi1 != 0) begin
                errors++; $display("FAIL pwm_duty0: window %0d high=%0d want 0", w, hi1);
            end
            checks++;
            if (hi2 != 255) begin
                errors++; $display("FAIL pwm_duty255: window %0d high=%0d want 255", w, hi2);
            end
        end
    endtask

    task automatic test_prescale_invert();
        logic a1, e1, a2, e2;
        logic [15:0] rd;
        logic p;
        int hi0, lo1, hi2, tr1;
        bus(32'hA4, 16'h0000, 2'b11, 1'b1, a1, e1, rd, a2, e2);
        bus(32'hA6, 16'h0080, 2'b11, 1'b1, a1, e1, rd, a2, e2);
        bus(32'hA2, 16'h0003, 2'b11, 1'b1, a1, e1, rd, a2, e2);
        bus(32'hA0, 16'h0003, 2'b11, 1'b1, a1, e1, rd, a2, e2);
        hi0 = 0; lo1 = 0; hi2 = 0; tr1 = 0;
        p = leds[1];
        for (int c = 0; c < 1024; c++) begin
            @(posedge clk); #1;
            if (leds[0]) hi0++;
            if (!leds[1]) lo1++;
            if (leds[2]) hi2++;
            if (leds[1] !== p) tr1++;
            p = leds[1];
        end
        checks++;
        if (lo1 != 512 || tr1 != 2) begin
            errors++; $display("FAIL prescale_inv_ch1: low=%0d edges=%0d want 512 2", lo1, tr1);
        end
        checks++;
        if (hi0 != 1024) begin
            errors++; $display("FAIL inv_duty0: high=%0d want 1024", hi0);
        end
        checks++;
        if (hi2 != 4) begin
            errors++; $display("FAIL inv_duty255: high=%0d want 4", hi2);
        end
        bus(32'hA0, 16'h0002, 2'b11, 1'b1, a1, e1, rd, a2, e2);
        checks++;
        if (leds !== 8'hFF) begin
            errors++; $display("FAIL en0_inv1: got leds=%h want ff", leds);
        end
        bus(32'hA0, 16'hFFFC, 2'b11, 1'b1, a1, e1, rd, a2, e2);
        checks++;
        if (leds !== 8'h00) begin
            errors++; $display("FAIL en0_inv0: got leds=%h want 00", leds);
        end
        bus(32'hA0, 16'h0000, 2'b11, 1'b0, a1, e1, rd, a2, e2);
        checks++;
        if (rd !== 16'h0000) begin
            errors++; $display("FAIL ctrl_upper_bits: got ctrl=%h want 0000", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic a1, e1, a2, e2;
        logic [15:0] rd;
        logic [4:0] acks;
        logic [4:0] errs;
        logic [15:0] rd_b2b;
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_sel = 2'b11;
        wb_addr = 32'hA4; wb_wdata = 16'hAA11;
        @(posedge clk); #1; acks[0] = wb_ack; errs[0] = wb_err;
        @(negedge clk); wb_addr = 32'hA6; wb_wdata = 16'h0022;
        @(posedge clk); #1; acks[1] = wb_ack; errs[1] = wb_err;
        @(negedge clk); wb_addr = 32'hA8; wb_wdata = 16'h0033;
        @(posedge clk); #1; acks[2] = wb_ack; errs[2] = wb_err;
        @(negedge clk); wb_we = 1'b0;
        @(posedge clk); #1; acks[3] = wb_ack; errs[3] = wb_err; rd_b2b = wb_rdata;
        @(negedge clk); wb_cyc = 1'b0; wb_stb = 1'b0;
        @(posedge clk); #1; acks[4] = wb_ack; errs[4] = wb_err;
        checks++;
        if (acks !== 5'b01111 || errs !== 5'b00000) begin
            errors++; $display("FAIL b2b_acks: got acks=%b errs=%b want 01111 00000", acks, errs);
        end
        checks++;
        if (rd_b2b !== 16'h0033) begin
            errors++; $display("FAIL read_after_write: got data=%h want 0033", rd_b2b);
        end
        bus(32'hA4, 16'h0000, 2'b11, 1'b0, a1, e1, rd, a2, e2);
        checks++;
        if (rd !== 16'h0011) begin
            errors++; $display("FAIL b2b_read0: got data=%h want 0011", rd);
        end
        bus(32'hA6, 16'h0000, 2'b11, 1'b0, a1, e1, rd, a2, e2);
        checks++;
        if (rd !== 16'h0022) begin
            errors++; $display("FAIL b2b_read1: got data=%h want 0022", rd);
        end
        bus(32'hA8, 16'h0000, 2'b11, 1'b0, a1, e1, rd, a2, e2);
        checks++;
        if (rd !== 16'h0033) begin
            errors++; $display("FAIL b2b_read2: got data=%h want 0033", rd);
        end
    endtask

    initial begin
        rst = 1'b1;
        wb_wdata = '0; wb_addr = '0; wb_cyc = 1'b0; wb_lock = 1'b0;
        wb_sel = '0; wb_stb = 1'b0; wb_we = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_byte_lanes();
        test_error();
        test_pwm();
        test_prescale_invert();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
